// File: rtl/phrase_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// phrase_sequencer
//
// Playback controller for the music datapath. It walks the phrase-ID table
// one address at a time. At each phrase boundary it latches the 5-bit phrase
// ID. It then splits every phrase into STEPS_PER_PHRASE note steps of
// TICKS_PER_STEP clock cycles each. The note/voice generators downstream
// consume phrase_id/step, and step_strobe marks each new value.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   1-cycle pulse: (re)start playback from START_ADDR
//   stop         in   1-cycle pulse: abort playback, return to IDLE
//   pause        in   level: freeze playback while high
//   loop_en      in   level: at end of song, 1 = jump to LOOP_ADDR, 0 = finish
//   db_addr      out  [7:0] phrase table address (registered)
//   db_entry     in   [4:0] phrase ID for db_addr (combinational table read)
//   phrase_id    out  [4:0] phrase ID of the current phrase
//   step         out  [3:0] note step within the phrase
//   step_strobe  out  1-cycle pulse when a new phrase_id/step is presented
//   playing      out  high in FETCH and PLAY
//   mute         out  high unless in PLAY with a non-zero phrase_id
//   song_done    out  high in DONE
// ----------------------------------------------------------------------------
module phrase_sequencer #(
    parameter int TICKS_PER_STEP   = 4,
    parameter int STEPS_PER_PHRASE = 16,
    parameter int START_ADDR       = 1,
    parameter int LAST_ADDR        = 152,
    parameter int LOOP_ADDR        = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop_en,
    output logic [7:0] db_addr,
    input  logic [4:0] db_entry,
    output logic [4:0] phrase_id,
    output logic [3:0] step,
    output logic       step_strobe,
    output logic       playing,
    output logic       mute,
    output logic       song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [15:0] TICK_LAST  = 16'(TICKS_PER_STEP - 1);
    localparam logic [3:0]  STEP_LAST  = 4'(STEPS_PER_PHRASE - 1);
    localparam logic [7:0]  ADDR_START = 8'(START_ADDR);
    localparam logic [7:0]  ADDR_LAST  = 8'(LAST_ADDR);
    localparam logic [7:0]  ADDR_LOOP  = 8'(LOOP_ADDR);

    state_t      r_state;
    logic [7:0]  r_db_addr;
    logic [4:0]  r_phrase_id;
    logic [3:0]  r_step;
    logic [15:0] r_tick_cnt;
    logic        r_step_strobe;

    // Command priority is stop > start > pause. Any state accepts start,
    // so a start while playing is a restart from START_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_db_addr     <= 8'd0;
            r_phrase_id   <= 5'd0;
            r_step        <= 4'd0;
            r_tick_cnt    <= 16'd0;
            r_step_strobe <= 1'b0;
        end else begin
            r_step_strobe <= 1'b0;
            if (stop) begin
                r_state     <= S_IDLE;
                r_db_addr   <= 8'd0;
                r_phrase_id <= 5'd0;
                r_step      <= 4'd0;
                r_tick_cnt  <= 16'd0;
            end else if (start) begin
                r_db_addr <= ADDR_START;
                r_state   <= S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        // FETCH is tick 0 of step 0. This keeps every phrase
                        // exactly STEPS_PER_PHRASE*TICKS_PER_STEP cycles long.
                        // A pause here is deferred to the next PLAY cycle.
                        r_phrase_id   <= db_entry;
                        r_step        <= 4'd0;
                        r_tick_cnt    <= 16'd1;
                        r_step_strobe <= 1'b1;
                        r_state       <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (pause) begin
                            r_state <= S_PAUSE;
                        end else if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= 16'd0;
                            if (r_step < STEP_LAST) begin
                                r_step        <= r_step + 4'd1;
                                r_step_strobe <= 1'b1;
                            end else if (r_db_addr < ADDR_LAST) begin
                                // The < compare keeps the address from passing
                                // LAST_ADDR or wrapping through 255.
                                r_db_addr <= r_db_addr + 8'd1;
                                r_state   <= S_FETCH;
                            end else if (loop_en) begin
                                r_db_addr <= ADDR_LOOP;
                                r_state   <= S_FETCH;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 16'd1;
                        end
                    end
                    S_PAUSE: begin
                        // The counters stay frozen, so playback resumes from
                        // the held tick_cnt.
                        if (!pause) begin
                            r_state <= S_PLAY;
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for start or stop.
                    end
                endcase
            end
        end
    end

    assign db_addr     = r_db_addr;
    assign phrase_id   = r_phrase_id;
    assign step        = r_step;
    assign step_strobe = r_step_strobe;

    // These outputs are decoded from the registered state.
    assign playing   = (r_state == S_FETCH) || (r_state == S_PLAY);
    assign mute      = !((r_state == S_PLAY) && (r_phrase_id != 5'd0));
    assign song_done = (r_state == S_DONE);

endmodule
